// File: rtl/cayde_pkg.sv
// Shared types and constants for the cayde register file.
// Holds the FSM state encoding, the default register width and the hardwired-zero index.
package cayde_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_ZERO     = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/cayde_regfile_rdport.sv
// One combinational read port: zero check, same-cycle write bypass, then storage/scoreboard lookup.
// Outputs are forced to zero until the clearing sweep has finished.
module cayde_regfile_rdport import cayde_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned AW   = 5
) (
  input  logic            i_ready,
  input  logic [AW-1:0]   i_raddr,
  input  logic            i_wen,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_mem_busy,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_rbusy
);

  logic w_zero;
  logic w_hit;

  assign w_zero = (i_raddr == AW'(REG_ZERO));
  assign w_hit  = i_wen && (i_waddr == i_raddr);

  // A bypassed write always reports not-busy, since it retires the producer this cycle.
  always_comb begin
    o_rdata = '0;
    o_rbusy = 1'b0;
    if (i_ready && !w_zero) begin
      if (w_hit) begin
        o_rdata = i_wdata;
      end else begin
        o_rdata = i_mem_data;
        o_rbusy = i_mem_busy;
      end
    end
  end

endmodule

// File: rtl/cayde_regfile_mp.sv
// Multi-read-port integer register file with write bypass and pending-write scoreboard.
// Storage has no reset; a post-reset sweep zeroes x1..x(NREGS-1) before ready_out rises.
module cayde_regfile_mp import cayde_pkg::*; #(
  parameter  int unsigned XLEN  = XLEN_DEFAULT,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] raddr_in,
  output logic [NRD*XLEN-1:0] rdata_out,
  output logic [NRD-1:0]    rbusy_out,
  input  logic [AW-1:0]     waddr_in,
  input  logic [XLEN-1:0]   wdata_in,
  input  logic              wen_in,
  input  logic              issue_en_in,
  input  logic [AW-1:0]     issue_addr_in,
  output logic              ready_out,
  output logic              write_fault_out
);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  rf_state_e        r_state;
  rf_state_e        w_state_nxt;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idx_nxt;
  logic             w_clr_we;
  logic             w_ready;
  logic             w_wr_ok;
  logic             w_iss_ok;
  logic             r_fault;

  assign w_ready  = (r_state == READY);
  assign w_wr_ok  = w_ready && wen_in && (waddr_in != AW'(REG_ZERO));
  assign w_iss_ok = w_ready && issue_en_in && (issue_addr_in != AW'(REG_ZERO));

  // Sweep FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_idx   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Sweep FSM next state: one register cleared per cycle, last one hands over to READY
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_clr_we    = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we  = 1'b1;
        w_idx_nxt = r_idx + AW'(1);
        if (r_idx == AW'(NREGS - 1)) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Storage: sweep writes take the port while clearing, writeback afterwards
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_idx] <= '0;
    end else if (w_wr_ok) begin
      r_mem[waddr_in] <= wdata_in;
    end
  end

  // Issue is applied after writeback so it wins on an address collision
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[waddr_in] = 1'b0;
    end
    if (w_iss_ok) begin
      w_busy_nxt[issue_addr_in] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_fault <= r_fault | (!w_ready && (wen_in || issue_en_in));
    end
  end

  assign ready_out       = w_ready;
  assign write_fault_out = r_fault;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] w_raddr;
    assign w_raddr = raddr_in[p*AW +: AW];

    cayde_regfile_rdport #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_rdport (
      .i_ready    (w_ready),
      .i_raddr    (w_raddr),
      .i_wen      (wen_in),
      .i_waddr    (waddr_in),
      .i_wdata    (wdata_in),
      .i_mem_data (r_mem[w_raddr]),
      .i_mem_busy (r_busy[w_raddr]),
      .o_rdata    (rdata_out[p*XLEN +: XLEN]),
      .o_rbusy    (rbusy_out[p])
    );
  end

endmodule
